// File: rtl/leaf_user_demux_1to3.sv
// ---------------------------------------------------------------------------
// leaf_user_demux_1to3
//
// Header-routed 1-to-3 stream demultiplexer on the user side of a leaf.
// Each packet is one header word followed by N payload words. The header
// selects an output port (dest 0/1/2 -> ports 1/2/3) or drop (dest 3), and
// carries N in bits [LEN_BITS+15:16]. Payload words are written into a small
// per-port FIFO whose head drives the matching output stream. The header
// itself is never forwarded.
//
// Ports:
//   clk_user                          user clock, the only clock
//   reset                             synchronous, active-high
//   dout_leaf_interface2user_1        input stream data
//   vld_interface2user_1              input word valid
//   ack_user2interface_1              input word accepted
//   din_leaf_user2interface_1/2/3     output stream data (FIFO head)
//   vld_user2interface_1/2/3          output word valid (FIFO non-empty)
//   ack_interface2user_1/2/3          output word accepted
//   pkt_count                         saturating count of headers, dest 0..2
//   drop_count                        saturating count of headers, dest 3
//   busy                              FSM outside HDR or any FIFO non-empty
// ---------------------------------------------------------------------------
module leaf_user_demux_1to3 #(
    parameter int PAYLOAD_BITS = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_BITS     = 16
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1,
    input  logic                    vld_interface2user_1,
    output logic                    ack_user2interface_1,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_2,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_3,
    output logic                    vld_user2interface_1,
    output logic                    vld_user2interface_2,
    output logic                    vld_user2interface_3,
    input  logic                    ack_interface2user_1,
    input  logic                    ack_interface2user_2,
    input  logic                    ack_interface2user_3,
    output logic [LEN_BITS-1:0]     pkt_count,
    output logic [LEN_BITS-1:0]     drop_count,
    output logic                    busy
);

    localparam int PTR_BITS = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [1:0]              r_dest;
    logic [LEN_BITS-1:0]     r_remain;
    logic [LEN_BITS-1:0]     r_pktCount;
    logic [LEN_BITS-1:0]     r_dropCount;

    logic                    w_inAck;
    logic                    w_inXfer;
    logic [1:0]              w_hdrDest;
    logic [LEN_BITS-1:0]     w_hdrLen;
    logic [3:0]              w_full;
    logic [2:0]              w_empty;
    logic [2:0]              w_outAck;
    logic [PAYLOAD_BITS-1:0] w_headData [3];

    assign w_hdrDest = dout_leaf_interface2user_1[1:0];
    assign w_hdrLen  = dout_leaf_interface2user_1[LEN_BITS+15:16];
    assign w_outAck  = {ack_interface2user_3, ack_interface2user_2, ack_interface2user_1};

    // The drop destination never owns a FIFO; tying its full flag high keeps
    // the r_dest index in range without a special case.
    assign w_full[3] = 1'b1;

    // Input ack looks only at registered state (FSM, latched dest, full
    // flags) so it never combinationally depends on the output-side acks.
    // A full FIFO stalls the input even if it is being popped this cycle.
    always_comb begin
        w_inAck = 1'b0;
        if (!reset) begin
            case (r_state)
                HDR:     w_inAck = 1'b1;
                FWD:     w_inAck = !w_full[r_dest];
                DROP:    w_inAck = 1'b1;
                default: w_inAck = 1'b0;
            endcase
        end
    end

    assign w_inXfer = w_inAck && vld_interface2user_1;

    // Packet parser: latches dest and length from the header, bumps the
    // matching counter once per header (including zero-length ones), and
    // counts payload words down until the packet ends.
    always_ff @(posedge clk_user) begin
        if (reset) begin
            r_state     <= HDR;
            r_dest      <= 2'd0;
            r_remain    <= '0;
            r_pktCount  <= '0;
            r_dropCount <= '0;
        end else begin
            case (r_state)
                HDR: begin
                    if (w_inXfer) begin
                        r_dest   <= w_hdrDest;
                        r_remain <= w_hdrLen;
                        if (w_hdrDest == 2'd3) begin
                            if (r_dropCount != '1)
                                r_dropCount <= r_dropCount + LEN_BITS'(1);
                            if (w_hdrLen != '0)
                                r_state <= DROP;
                        end else begin
                            if (r_pktCount != '1)
                                r_pktCount <= r_pktCount + LEN_BITS'(1);
                            if (w_hdrLen != '0)
                                r_state <= FWD;
                        end
                    end
                end
                FWD, DROP: begin
                    if (w_inXfer) begin
                        r_remain <= r_remain - LEN_BITS'(1);
                        if (r_remain == LEN_BITS'(1))
                            r_state <= HDR;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    // One FIFO per output port. Pointers wrap naturally because the depth
    // is a power of two; the separate occupancy count distinguishes full
    // from empty.
    for (genvar k = 0; k < 3; k++) begin : g_fifo
        logic [PAYLOAD_BITS-1:0] r_mem [FIFO_DEPTH];
        logic [PTR_BITS-1:0]     r_wrPtr;
        logic [PTR_BITS-1:0]     r_rdPtr;
        logic [CNT_BITS-1:0]     r_count;
        logic                    w_push;
        logic                    w_pop;

        assign w_push    = w_inXfer && (r_state == FWD) && (r_dest == 2'(k));
        assign w_pop     = !w_empty[k] && w_outAck[k];
        assign w_full[k]  = (r_count == CNT_BITS'(FIFO_DEPTH));
        assign w_empty[k] = (r_count == '0);

        // Head data is forced to zero while empty so the output bus reads
        // zero out of reset without needing to clear the storage array.
        assign w_headData[k] = w_empty[k] ? '0 : r_mem[r_rdPtr];

        // Pointer and occupancy bookkeeping; a simultaneous push and pop
        // leaves the occupancy unchanged.
        always_ff @(posedge clk_user) begin
            if (reset) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push)
                    r_wrPtr <= r_wrPtr + PTR_BITS'(1);
                if (w_pop)
                    r_rdPtr <= r_rdPtr + PTR_BITS'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_BITS'(1);
                    2'b01:   r_count <= r_count - CNT_BITS'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        // Storage is written without reset; stale contents are never
        // visible because the head is masked while the FIFO is empty.
        always_ff @(posedge clk_user) begin
            if (w_push)
                r_mem[r_wrPtr] <= dout_leaf_interface2user_1;
        end
    end

    assign ack_user2interface_1      = w_inAck;
    assign din_leaf_user2interface_1 = w_headData[0];
    assign din_leaf_user2interface_2 = w_headData[1];
    assign din_leaf_user2interface_3 = w_headData[2];
    assign vld_user2interface_1      = !w_empty[0];
    assign vld_user2interface_2      = !w_empty[1];
    assign vld_user2interface_3      = !w_empty[2];
    assign pkt_count                 = r_pktCount;
    assign drop_count                = r_dropCount;
    assign busy                      = (r_state != HDR) || (w_empty != 3'b111);

endmodule

// File: tb/tb_leaf_user_demux_1to3.sv
// ---------------------------------------------------------------------------
// tb_leaf_user_demux_1to3
//
// Scoreboard bench for leaf_user_demux_1to3. Every payload word that the
// input handshake accepts is queued on its expected output port; the port
// monitor pops and compares as words leave the DUT. Counters are tracked
// by a small saturating model.
// ---------------------------------------------------------------------------
module tb_leaf_user_demux_1to3;

   localparam int PB = 32;
   localparam int FD = 4;
   localparam int LB = 16;

   typedef struct {
      logic [PB-1:0] data;
      int            accCyc;
   } exp_t;

   logic          clk_user = 1'b0;
   logic          reset;
   logic [PB-1:0] dinIn;
   logic          vldIn;
   logic          ackIn;
   logic [PB-1:0] dout1, dout2, dout3;
   logic          vld1, vld2, vld3;
   logic          ack1, ack2, ack3;
   logic [LB-1:0] pktCount;
   logic [LB-1:0] dropCount;
   logic          busy;

   int   totalChecks = 0;
   int   badChecks   = 0;
   int   cyc         = 0;
   int   nAccepted   = 0;
   int   expPkt      = 0;
   int   expDrop     = 0;
   bit   chkLatency  = 1'b0;
   bit   randAcks    = 1'b0;
   exp_t expQ0[$];
   exp_t expQ1[$];
   exp_t expQ2[$];

   leaf_user_demux_1to3 #(
      .PAYLOAD_BITS(PB),
      .FIFO_DEPTH(FD),
      .LEN_BITS(LB)
   ) dut (
      .clk_user(clk_user),
      .reset(reset),
      .dout_leaf_interface2user_1(dinIn),
      .vld_interface2user_1(vldIn),
      .ack_user2interface_1(ackIn),
      .din_leaf_user2interface_1(dout1),
      .din_leaf_user2interface_2(dout2),
      .din_leaf_user2interface_3(dout3),
      .vld_user2interface_1(vld1),
      .vld_user2interface_2(vld2),
      .vld_user2interface_3(vld3),
      .ack_interface2user_1(ack1),
      .ack_interface2user_2(ack2),
      .ack_interface2user_3(ack3),
      .pkt_count(pktCount),
      .drop_count(dropCount),
      .busy(busy)
   );

   // Free-running clock and cycle counter used for latency checks.
   always #5 clk_user = ~clk_user;

   always @(posedge clk_user) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [PB-1:0] act, input logic [PB-1:0] exp);
      totalChecks++;
      if (act !== exp) begin
         badChecks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [PB-1:0] mkHdr(input int len, input int dest);
      logic [PB-1:0] h;
      logic [31:0]   l;
      logic [31:0]   d;
      l        = 32'(len);
      d        = 32'(dest);
      h        = '0;
      h[15:2]  = 14'h1A5;
      h[31:16] = l[15:0];
      h[1:0]   = d[1:0];
      return h;
   endfunction

   task automatic qPush(input int k, input exp_t e);
      case (k)
         0:       expQ0.push_back(e);
         1:       expQ1.push_back(e);
         default: expQ2.push_back(e);
      endcase
   endtask

   function automatic int qSize(input int k);
      case (k)
         0:       return expQ0.size();
         1:       return expQ1.size();
         default: return expQ2.size();
      endcase
   endfunction

   task automatic qPop(input int k, output exp_t e);
      case (k)
         0:       e = expQ0.pop_front();
         1:       e = expQ1.pop_front();
         default: e = expQ2.pop_front();
      endcase
   endtask

   // Output monitor for one port: any valid word must be expected, and a
   // transferring word must match the head of that port's queue.
   task automatic monitorPort(input int k, input logic v, input logic a, input logic [PB-1:0] d);
      exp_t e;
      if (v) begin
         if (qSize(k) == 0) begin
            checkOutput($sformatf("port%0d unexpected vld", k + 1), 1, 0);
         end else if (a) begin
            qPop(k, e);
            checkOutput($sformatf("port%0d data", k + 1), d, e.data);
            if (chkLatency)
               checkOutput($sformatf("port%0d latency", k + 1), cyc, e.accCyc + 1);
         end
      end
   endtask

   // Sample outputs on the falling edge; inputs are only changed just
   // after the rising edge, so these are the values the next edge sees.
   always @(negedge clk_user) begin
      if (!reset) begin
         monitorPort(0, vld1, ack1, dout1);
         monitorPort(1, vld2, ack2, dout2);
         monitorPort(2, vld3, ack3, dout3);
      end
   end

   // Random backpressure on all three output ports when enabled.
   always @(posedge clk_user) begin
      if (randAcks) begin
         #1;
         ack1 = 1'($urandom_range(0, 1));
         ack2 = 1'($urandom_range(0, 1));
         ack3 = 1'($urandom_range(0, 1));
      end
   end

   // Drive one input word and hold it until accepted (bounded wait).
   task automatic applyStimulus(input logic [PB-1:0] word, input bit isPayload, input int dest);
      int waited;
      bit done;
      waited = 0;
      done   = 1'b0;
      dinIn  = word;
      vldIn  = 1'b1;
      while (!done) begin
         @(negedge clk_user);
         if (ackIn) begin
            done = 1'b1;
            if (isPayload) begin
               nAccepted++;
               if (dest < 3) qPush(dest, '{word, cyc});
            end
         end else begin
            waited++;
            if (waited > 1000) begin
               checkOutput("input ack timeout", 0, 1);
               done = 1'b1;
            end
         end
         @(posedge clk_user);
         #1;
      end
   endtask

   task automatic sendPacket(input int len, input int dest);
      applyStimulus(mkHdr(len, dest), 1'b0, dest);
      if (dest == 3) begin
         if (expDrop < 65535) expDrop++;
      end else begin
         if (expPkt < 65535) expPkt++;
      end
      for (int i = 0; i < len; i++)
         applyStimulus(PB'($urandom), 1'b1, dest);
      vldIn = 1'b0;
   endtask

   // One-cycle synchronous reset followed by checks of the reset state.
   task automatic applyReset();
      @(posedge clk_user);
      #1;
      reset = 1'b1;
      vldIn = 1'b0;
      @(posedge clk_user);
      #1;
      checkOutput("ack low during reset", ackIn, 0);
      reset = 1'b0;
      expQ0.delete();
      expQ1.delete();
      expQ2.delete();
      expPkt    = 0;
      expDrop   = 0;
      nAccepted = 0;
      #1;
      checkOutput("ack after reset", ackIn, 1);
      checkOutput("vld after reset", {vld3, vld2, vld1}, 0);
      checkOutput("din1 after reset", dout1, 0);
      checkOutput("din3 after reset", dout3, 0);
      checkOutput("pkt_count after reset", pktCount, 0);
      checkOutput("drop_count after reset", dropCount, 0);
      checkOutput("busy after reset", busy, 0);
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while ((qSize(0) + qSize(1) + qSize(2) != 0 || busy) && n < 500) begin
         @(posedge clk_user);
         #1;
         n++;
      end
      checkOutput({tag, " queued words left"}, qSize(0) + qSize(1) + qSize(2), 0);
      checkOutput({tag, " busy"}, busy, 0);
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, " pkt_count"}, pktCount, PB'(expPkt));
      checkOutput({tag, " drop_count"}, dropCount, PB'(expDrop));
   endtask

   initial begin
      reset = 1'b1;
      dinIn = '0;
      vldIn = 1'b0;
      ack1  = 1'b1;
      ack2  = 1'b1;
      ack3  = 1'b1;

      // Three words to port 2 with the output always ready.
      applyReset();
      chkLatency = 1'b1;
      sendPacket(3, 1);
      waitDrain("t1");
      chkLatency = 1'b0;
      checkCounters("t1");
      checkOutput("t1 pkt_count is one", pktCount, 1);

      // Port 1 stalled: only the FIFO depth is accepted, then drain.
      ack1 = 1'b0;
      applyReset();
      fork
         sendPacket(6, 0);
         begin
            repeat (12) @(negedge clk_user);
            checkOutput("t2 accepted before stall", nAccepted, FD);
            checkOutput("t2 input ack stalled", ackIn, 0);
            checkOutput("t2 busy while stalled", busy, 1);
            @(posedge clk_user);
            #1;
            ack1 = 1'b1;
         end
      join
      waitDrain("t2");
      checkOutput("t2 total accepted", nAccepted, 6);

      // Dropped packet then a zero-length header to port 3.
      applyReset();
      sendPacket(2, 3);
      sendPacket(0, 2);
      repeat (2) @(posedge clk_user);
      #1;
      checkCounters("t3");
      checkOutput("t3 ack in HDR", ackIn, 1);
      waitDrain("t3");

      // Back-to-back packets to ports 3, 1, 2 with random output acks.
      applyReset();
      randAcks = 1'b1;
      sendPacket(5, 2);
      sendPacket(7, 0);
      sendPacket(6, 1);
      waitDrain("t4");
      randAcks = 1'b0;
      @(posedge clk_user);
      #2;
      ack1 = 1'b1;
      ack2 = 1'b1;
      ack3 = 1'b1;
      checkCounters("t4");

      // Reset in the middle of a 5-word packet to port 1.
      ack1 = 1'b0;
      applyReset();
      applyStimulus(mkHdr(5, 0), 1'b0, 0);
      applyStimulus(PB'(32'hDEAD0001), 1'b1, 0);
      applyStimulus(PB'(32'hDEAD0002), 1'b1, 0);
      vldIn = 1'b0;
      checkOutput("t5 port1 holding data", vld1, 1);
      applyReset();
      ack1 = 1'b1;
      sendPacket(1, 1);
      waitDrain("t5");
      checkCounters("t5");

      // Counter saturation with 2^LB zero-length headers.
      applyReset();
      for (int i = 0; i < (1 << LB); i++)
         sendPacket(0, i % 3);
      repeat (2) @(posedge clk_user);
      #1;
      checkOutput("t6 pkt_count saturated", pktCount, 32'h0000FFFF);
      checkCounters("t6");

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
